// File: rtl/demux_pkg.sv
// Shared types and defaults for the round-robin demux scheduler.
// Optional feature macro: DEMUX_TIMEOUT_EN (stall timeout with drop pulse).
package demux_pkg;

   localparam int NUM_OUT         = 4;
   localparam int DATA_W_DEF      = 8;
   localparam int TIMEOUT_CYC_DEF = 15;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin next-index picker: first enabled index strictly after last_ptr,
// wrapping, with last_ptr itself considered last.
module rr_pick
   import demux_pkg::*;
(
   input  logic [1:0]         last_ptr,
   input  logic [NUM_OUT-1:0] mask,
   output logic [1:0]         next_idx,
   output logic               next_vld
);

   // Scan farthest candidate first so the nearest enabled one wins.
   always_comb begin
      next_idx = 2'd0;
      next_vld = 1'b0;
      for (int k = NUM_OUT; k >= 1; k--) begin
         if (mask[last_ptr + 2'(k)]) begin
            next_idx = last_ptr + 2'(k);
            next_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/demux_rr_sched.sv
// Single-word buffered demux that routes each accepted word to the next enabled
// destination in round-robin order. One cycle latency, one word per cycle.
// Optional feature macro: DEMUX_TIMEOUT_EN adds a stall timeout that discards
// the held word and pulses drop.
//
// state  | meaning
// S_IDLE | buffer empty, may accept when any destination is enabled
// S_HOLD | buffer full, word presented to destination sel
module demux_rr_sched
   import demux_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_data,
   output logic               in_ready,
   input  logic [NUM_OUT-1:0] dest_en,
   output logic [NUM_OUT-1:0] out_valid,
   output logic [DATA_W-1:0]  out_data,
   input  logic [NUM_OUT-1:0] out_ready,
   output logic [1:0]         sel,
   output logic [15:0]        xfer_cnt,
   output logic               drop
);

   state_t              state_q, state_d;
   logic [1:0]          sel_q, sel_d;
   logic [1:0]          last_q, last_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [15:0]         xfer_q, xfer_d;
   logic [1:0]          pick_idx;
   logic                pick_vld;
   logic                complete;
   logic                accept;

   rr_pick u_rr_pick (
      .last_ptr (last_q),
      .mask     (dest_en),
      .next_idx (pick_idx),
      .next_vld (pick_vld)
   );

`ifdef DEMUX_TIMEOUT_EN
   localparam int STALL_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [STALL_W-1:0] STALL_LOAD = STALL_W'(TIMEOUT_CYC - 1);

   logic [STALL_W-1:0] stall_q, stall_d;
   logic               timeout;

   // Down-counter of remaining stall cycles; reloads on capture and completion.
   always_comb begin
      stall_d = stall_q;
      timeout = 1'b0;
      if (accept || complete) begin
         stall_d = STALL_LOAD;
      end else if (state_q == S_HOLD) begin
         if (stall_q == '0) begin
            timeout = 1'b1;
         end else begin
            stall_d = stall_q - 1'b1;
         end
      end
   end

   // Stall counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_q <= STALL_LOAD;
      else        stall_q <= stall_d;
   end

   assign drop = timeout;
`else
   logic timeout;
   assign timeout = 1'b0;
   assign drop    = 1'b0;
`endif

   // Next-state, datapath and handshake outputs.
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      last_d    = last_q;
      data_d    = data_q;
      xfer_d    = xfer_q;
      in_ready  = 1'b0;
      out_valid = '0;
      complete  = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = pick_vld;
         end
         S_HOLD: begin
            out_valid = {{(NUM_OUT-1){1'b0}}, 1'b1} << sel_q;
            complete  = out_ready[sel_q];
            in_ready  = complete & pick_vld;
         end
         default: state_d = S_IDLE;
      endcase
      accept = in_valid & in_ready;
      if (complete) begin
         xfer_d  = xfer_q + 16'd1;
         state_d = S_IDLE;
      end
      if (timeout) begin
         state_d = S_IDLE;
      end
      if (accept) begin
         data_d  = in_data;
         sel_d   = pick_idx;
         last_d  = pick_idx;
         state_d = S_HOLD;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sel_q   <= 2'd0;
         last_q  <= 2'd3;
         data_q  <= '0;
         xfer_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         data_q  <= data_d;
         xfer_q  <= xfer_d;
      end
   end

   assign out_data = data_q;
   assign sel      = sel_q;
   assign xfer_cnt = xfer_q;

endmodule

// File: tb/tb_demux_rr_sched.sv
// Directed bench for the round-robin demux scheduler.
module tb_demux_rr_sched;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic [3:0]  dest_en;
   logic [3:0]  out_valid;
   logic [7:0]  out_data;
   logic [3:0]  out_ready;
   logic [1:0]  sel;
   logic [15:0] xfer_cnt;
   logic        drop;

   int vectors = 0;
   int errors  = 0;

   demux_rr_sched #(.DATA_W(8), .TIMEOUT_CYC(15)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .dest_en   (dest_en),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .sel       (sel),
      .xfer_cnt  (xfer_cnt),
      .drop      (drop)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      dest_en   = 4'b0000;
      out_ready = 4'b0000;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_sel",       32'(sel),       32'h0);
      chk("rst_out_data",  32'(out_data),  32'h0);
      chk("rst_xfer_cnt",  32'(xfer_cnt),  32'h0);
      chk("rst_drop",      32'(drop),      32'h0);
      #20;
      rst_n = 1'b1;
      tick();

      // Rotation over all four destinations, one word per cycle.
      dest_en   = 4'b1111;
      out_ready = 4'b1111;
      in_valid  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_data = 8'hA0 + 8'(i);
         #1;
         chk("rot_in_ready", 32'(in_ready), 32'h1);
         tick();
         chk("rot_sel",       32'(sel),       32'(i % 4));
         chk("rot_out_valid", 32'(out_valid), 32'(4'b0001 << (i % 4)));
         chk("rot_out_data",  32'(out_data),  32'(8'hA0 + i));
         chk("rot_xfer_cnt",  32'(xfer_cnt),  32'(i));
      end
      in_valid = 1'b0;
      tick();
      chk("rot_final_xfer", 32'(xfer_cnt),  32'd8);
      chk("rot_idle_valid", 32'(out_valid), 32'h0);

      // Masked rotation: only destinations 1 and 3.
      dest_en  = 4'b1010;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = 8'hB0 + 8'(i);
         tick();
         chk("mask_sel",       32'(sel),       (i % 2 == 0) ? 32'd1 : 32'd3);
         chk("mask_out_valid", 32'(out_valid), (i % 2 == 0) ? 32'h2 : 32'h8);
      end
      in_valid = 1'b0;
      tick();
      chk("mask_xfer", 32'(xfer_cnt), 32'd12);

      // Empty mask: nothing accepted.
      dest_en  = 4'b0000;
      in_valid = 1'b1;
      in_data  = 8'hEE;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("empty_in_ready",  32'(in_ready),  32'h0);
         chk("empty_out_valid", 32'(out_valid), 32'h0);
         tick();
      end
      chk("empty_xfer", 32'(xfer_cnt), 32'd12);

      // Backpressure at destination 0; other ready bits are ignored.
      dest_en   = 4'b1111;
      out_ready = 4'b1110;
      in_data   = 8'h5A;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk("bp_out_valid", 32'(out_valid), 32'h1);
         chk("bp_out_data",  32'(out_data),  32'h5A);
         chk("bp_in_ready",  32'(in_ready),  32'h0);
         chk("bp_drop",      32'(drop),      32'h0);
         chk("bp_xfer",      32'(xfer_cnt),  32'd12);
         tick();
      end
      out_ready = 4'b0001;
      tick();
      chk("bp_done_xfer",  32'(xfer_cnt),  32'd13);
      chk("bp_done_valid", 32'(out_valid), 32'h0);

      // Single enabled destination: every word goes to index 2.
      dest_en   = 4'b0100;
      out_ready = 4'b0100;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 8'hC0 + 8'(i);
         tick();
         chk("single_sel",  32'(sel),      32'd2);
         chk("single_data", 32'(out_data), 32'(8'hC0 + i));
      end
      in_valid = 1'b0;
      tick();
      chk("single_xfer", 32'(xfer_cnt), 32'd16);

      // Reset asserted while holding a word at sel 3.
      dest_en   = 4'b1111;
      out_ready = 4'b0000;
      in_valid  = 1'b1;
      in_data   = 8'hD3;
      tick();
      in_valid = 1'b0;
      chk("midrst_pre_sel", 32'(sel), 32'd3);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'h0);
      chk("midrst_xfer",      32'(xfer_cnt),  32'h0);
      chk("midrst_drop",      32'(drop),      32'h0);
      tick();
      rst_n     = 1'b1;
      out_ready = 4'b1111;
      in_valid  = 1'b1;
      in_data   = 8'hD0;
      tick();
      in_valid = 1'b0;
      chk("midrst_next_sel",  32'(sel),      32'd0);
      chk("midrst_next_data", 32'(out_data), 32'hD0);
      tick();
      chk("midrst_next_xfer", 32'(xfer_cnt), 32'd1);

`ifdef DEMUX_TIMEOUT_EN
      // Destination never readies: drop on the 15th HOLD cycle.
      out_ready = 4'b0000;
      in_valid  = 1'b1;
      in_data   = 8'hE0;
      tick();
      in_valid = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         chk("to_out_valid", 32'(out_valid), 32'h2);
         chk("to_drop",      32'(drop),      (k == 15) ? 32'h1 : 32'h0);
         tick();
      end
      chk("to_idle_valid", 32'(out_valid), 32'h0);
      chk("to_drop_clear", 32'(drop),      32'h0);
      chk("to_xfer",       32'(xfer_cnt),  32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
